// File: rtl/btn_conditioner_pkg.sv
// Shared constants, channel indices and repeat-FSM encoding for the button front-end.
// Imported by the interface, the per-channel conditioner and the top level.
package btn_conditioner_pkg;

    localparam int unsigned BTN_HH   = 0;
    localparam int unsigned BTN_MM   = 1;
    localparam int unsigned BTN_SS   = 2;
    localparam int unsigned BTN_SAFE = 3;

    localparam int unsigned DEF_N_BTN     = 4;
    localparam int unsigned DEF_PRESCALE  = 32;
    localparam int unsigned DEF_DEB_TICKS = 20;
    localparam int unsigned DEF_RPT_DELAY = 512;
    localparam int unsigned DEF_RPT_RATE  = 128;

    localparam logic [DEF_N_BTN-1:0] DEF_ACT_LOW_MASK = 4'b1000;
    localparam logic [DEF_N_BTN-1:0] DEF_RPT_MASK     = 4'b0011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_DLY = 2'd1,
        HOLD_RPT = 2'd2
    } rpt_state_t;

    // Bits needed to hold values 0..n inclusive, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw pins and the conditioned strobes.
// The conditioner is the slave side; whoever drives the pins is the master.
interface btn_conditioner_if
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN = DEF_N_BTN
) ();

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_rpt;
    logic             tick;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_rpt,
        input  tick
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_rpt,
        output tick
    );

endinterface

// File: rtl/btn_conditioner_chan.sv
// One button channel: 2-flop synchronizer, tick-based debounce, press edge
// detect and the auto-repeat state machine.
module btn_chan
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DEB_TICKS = DEF_DEB_TICKS,
    parameter int unsigned RPT_DELAY = DEF_RPT_DELAY,
    parameter int unsigned RPT_RATE  = DEF_RPT_RATE,
    parameter bit          ACT_LOW   = 1'b0,
    parameter bit          RPT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rpt
);

    localparam int unsigned DW = cnt_width(DEB_TICKS);
    localparam int unsigned RW = cnt_width(umax(RPT_DELAY, RPT_RATE));

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(RPT_RATE - 1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] deb_cnt;
    logic          deb_fire;
    logic          rise;
    logic          fall;

    rpt_state_t    state;
    rpt_state_t    state_nxt;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_nxt;
    logic          rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ ACT_LOW;
            sync2 <= sync1;
        end
    end

    // The change is accepted on the tick that would bring the count to DEB_TICKS.
    assign deb_fire = tick && (sync2 != level) && (deb_cnt == DEB_LAST);
    assign rise     = deb_fire && !level;
    assign fall     = deb_fire && level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (tick) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_cnt <= '0;
                end else if (deb_cnt != '1) begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
            if (deb_fire) begin
                level <= ~level;
            end
            press <= rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!RPT_EN) begin
            state_nxt = IDLE;
        end else if (fall) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (rise) state_nxt = HOLD_DLY;
                HOLD_DLY: if (tick && rpt_cnt == DLY_LAST) state_nxt = HOLD_RPT;
                HOLD_RPT: state_nxt = HOLD_RPT;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // Release wins over a coinciding repeat so letting go never strobes.
    always_comb begin
        rpt_fire    = 1'b0;
        rpt_cnt_nxt = rpt_cnt;
        case (state)
            IDLE: begin
                rpt_cnt_nxt = '0;
            end
            HOLD_DLY: begin
                if (tick) begin
                    if (rpt_cnt == DLY_LAST) begin
                        rpt_fire    = 1'b1;
                        rpt_cnt_nxt = '0;
                    end else if (rpt_cnt != '1) begin
                        rpt_cnt_nxt = rpt_cnt + 1'b1;
                    end
                end
            end
            HOLD_RPT: begin
                if (tick) begin
                    if (rpt_cnt == RATE_LAST) begin
                        rpt_fire    = 1'b1;
                        rpt_cnt_nxt = '0;
                    end else if (rpt_cnt != '1) begin
                        rpt_cnt_nxt = rpt_cnt + 1'b1;
                    end
                end
            end
            default: begin
                rpt_cnt_nxt = '0;
            end
        endcase
        if (fall || !RPT_EN) begin
            rpt_fire    = 1'b0;
            rpt_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
            rpt     <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
            rpt     <= rise | rpt_fire;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front-end for the 32768 Hz clock core: shared debounce-tick
// prescaler plus one conditioning channel per button pin.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned      N_BTN        = DEF_N_BTN,
    parameter int unsigned      PRESCALE     = DEF_PRESCALE,
    parameter int unsigned      DEB_TICKS    = DEF_DEB_TICKS,
    parameter int unsigned      RPT_DELAY    = DEF_RPT_DELAY,
    parameter int unsigned      RPT_RATE     = DEF_RPT_RATE,
    parameter logic [N_BTN-1:0] ACT_LOW_MASK = N_BTN'(DEF_ACT_LOW_MASK),
    parameter logic [N_BTN-1:0] RPT_MASK     = N_BTN'(DEF_RPT_MASK)
) (
    input  logic               clk,
    input  logic               rst_n,
    btn_conditioner_if.slave   btn
);

    localparam int unsigned   PW     = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] rpt_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (pcnt == P_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == P_LAST);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .DEB_TICKS (DEB_TICKS),
            .RPT_DELAY (RPT_DELAY),
            .RPT_RATE  (RPT_RATE),
            .ACT_LOW   (ACT_LOW_MASK[i]),
            .RPT_EN    (RPT_MASK[i])
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (btn.btn_raw[i]),
            .level (level_v[i]),
            .press (press_v[i]),
            .rpt   (rpt_v[i])
        );
    end

    assign btn.btn_level = level_v;
    assign btn.btn_press = press_v;
    assign btn.btn_rpt   = rpt_v;
    assign btn.tick      = tick;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomized scoreboard bench for btn_conditioner with an arithmetic
// reference model of tick timing, debounce acceptance and repeat schedule.
module tb_btn_conditioner;

    localparam int P   = 4;
    localparam int DEB = 3;
    localparam int RD  = 5;
    localparam int RR  = 2;
    localparam logic [3:0] ACT_LOW = 4'b1000;
    localparam logic [3:0] RMASK   = 4'b0011;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rpt;
        logic       tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    btn_conditioner_if #(.N_BTN(4)) bif ();

    btn_conditioner #(
        .N_BTN        (4),
        .PRESCALE     (P),
        .DEB_TICKS    (DEB),
        .RPT_DELAY    (RD),
        .RPT_RATE     (RR),
        .ACT_LOW_MASK (ACT_LOW),
        .RPT_MASK     (RMASK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bif.slave)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    logic [3:0] raw_drive;
    logic       rst_drive;

    // Reference model state: t counts clock edges since reset release.
    int         t;
    logic [3:0] m_lvl, m_s2, r_last, m_press, m_rpt;
    int         dis_start[4];
    int         press_t[4];

    // Monitor-side observations of the DUT.
    int         last_rise[4];
    int         press_seen[4];
    int         rpt_seen[4];

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / P - a / P;
    endfunction

    task automatic model_reset();
        t       = 0;
        m_lvl   = '0;
        m_s2    = '0;
        r_last  = '0;
        m_press = '0;
        m_rpt   = '0;
        for (int ch = 0; ch < 4; ch++) begin
            dis_start[ch] = 0;
            press_t[ch]   = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] rmask;
        logic       tick_prev, toggle, prev_agree, new_lvl;
        int         d;
        rmask = RMASK;
        if (!rst_n) begin
            model_reset();
            return;
        end
        t++;
        tick_prev = ((t - 1) % P) == (P - 1);
        for (int ch = 0; ch < 4; ch++) begin
            toggle     = (m_s2[ch] != m_lvl[ch]) && tick_prev &&
                         (ticks_in(dis_start[ch], t - 1) == DEB);
            prev_agree = (m_s2[ch] == m_lvl[ch]);
            new_lvl    = m_lvl[ch] ^ toggle;
            m_press[ch] = toggle && new_lvl;
            if (m_press[ch]) press_t[ch] = t;
            m_lvl[ch] = new_lvl;
            m_s2[ch]  = r_last[ch];
            if ((m_s2[ch] != m_lvl[ch]) && (toggle || prev_agree)) dis_start[ch] = t;
            d = t - press_t[ch];
            m_rpt[ch] = m_press[ch] ||
                        (rmask[ch] && m_lvl[ch] && d >= RD * P && ((d - RD * P) % (RR * P)) == 0);
        end
        r_last = bif.btn_raw ^ ACT_LOW;
    endtask

    // One negedge: advance the model over the edge just passed, apply new
    // stimulus, and queue what the DUT must show for the coming half cycle.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        model_step();
        bif.btn_raw = raw_drive;
        rst_n       = rst_drive;
        if (!rst_n) model_reset();
        e.level = m_lvl;
        e.press = m_press;
        e.rpt   = m_rpt;
        e.tick  = rst_n && ((t % P) == (P - 1));
        sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic check_eq(input string name, input int val, input int req);
        checks++;
        if (val != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, val, req);
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] prev_lvl;
        prev_lvl = '0;
        forever begin
            @(negedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks += 4;
                if (bif.btn_level !== e.level) begin
                    failures++;
                    $display("FAIL level cyc=%0d got=%b exp=%b", cyc, bif.btn_level, e.level);
                end
                if (bif.btn_press !== e.press) begin
                    failures++;
                    $display("FAIL press cyc=%0d got=%b exp=%b", cyc, bif.btn_press, e.press);
                end
                if (bif.btn_rpt !== e.rpt) begin
                    failures++;
                    $display("FAIL rpt cyc=%0d got=%b exp=%b", cyc, bif.btn_rpt, e.rpt);
                end
                if (bif.tick !== e.tick) begin
                    failures++;
                    $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, bif.tick, e.tick);
                end
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (bif.btn_level[ch] && !prev_lvl[ch]) last_rise[ch] = cyc;
                if (bif.btn_press[ch]) press_seen[ch]++;
                if (bif.btn_rpt[ch]) rpt_seen[ch]++;
            end
            prev_lvl = bif.btn_level;
        end
    end

    initial begin : stimulus
        int n0;
        for (int ch = 0; ch < 4; ch++) begin
            last_rise[ch]  = -1;
            press_seen[ch] = 0;
            rpt_seen[ch]   = 0;
        end
        rst_n       = 1'b1;
        bif.btn_raw = '0;
        raw_drive   = '0;
        rst_drive   = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;

        // Reset, then free-running ticks; SAFE pin reads 0 so it debounces to pressed.
        run(10);
        rst_drive = 1'b1;
        run(40);

        // Bounce on HH shorter than the debounce window.
        press_seen[0] = 0;
        for (int i = 0; i < 12; i++) begin
            raw_drive[0] = ~raw_drive[0];
            run($urandom_range(2, 7));
        end
        raw_drive[0] = 1'b0;
        run(20);
        check_eq("bounce_press0", press_seen[0], 0);

        // Clean HH press at a random tick phase, held into auto-repeat, released.
        run($urandom_range(0, 7));
        last_rise[0] = -1;
        raw_drive[0] = 1'b1;
        cycle();
        n0 = cyc;
        run($urandom_range(45, 70));
        check_range("press0_latency", last_rise[0] - n0, 11, 15);
        raw_drive[0] = 1'b0;
        run(40);

        // Re-press restarts the initial repeat delay.
        raw_drive[0] = 1'b1;
        run(50);
        raw_drive[0] = 1'b0;
        run(30);

        // SS has no auto-repeat: one press and one rpt strobe over a long hold.
        press_seen[2] = 0;
        rpt_seen[2]   = 0;
        raw_drive[2]  = 1'b1;
        run(200);
        check_eq("ss_press_count", press_seen[2], 1);
        check_eq("ss_rpt_count", rpt_seen[2], 1);
        raw_drive[2] = 1'b0;
        run(30);

        // Reset while MM sits in the repeat delay, pin held through release.
        raw_drive[1] = 1'b1;
        run($urandom_range(20, 25));
        rst_drive = 1'b0;
        run(3);
        last_rise[1] = -1;
        rst_drive    = 1'b1;
        cycle();
        n0 = cyc;
        run(40);
        check_range("mm_repress_latency", last_rise[1] - n0, 11, 15);
        raw_drive[1] = 1'b0;
        run(30);

        // Random activity on all channels.
        for (int i = 0; i < 700; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 99) < 2) raw_drive[ch] = ~raw_drive[ch];
            end
            cycle();
        end
        run(2);
        #2;
        check_eq("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
